// File: rtl/johnson_monitor.sv
// Johnson counter stream monitor: decodes phase, tracks lock and counts completed cycles.
// Optional wraps counter is built when JOHNSON_MON_WRAP_EN is defined.
module johnson_monitor #(
    parameter int LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_code,
    input  logic       err_clr,
    output logic [3:0] phase,
    output logic       phase_valid,
    output logic       locked,
    output logic       illegal,
    output logic       err,
    output logic [7:0] wraps
);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

    // A Johnson code is a run of ones anchored at bit 0 (bit7 low) or at bit 7 (bit7 high);
    // folding the second case by inversion leaves a 2^k-1 mask check.
    function automatic logic is_legal(input logic [7:0] c);
        logic [7:0] m;
        m = c[7] ? ~c : c;
        return (m & (m + 8'd1)) == 8'd0;
    endfunction

    function automatic logic [3:0] decode(input logic [7:0] c);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) ones = ones + {3'd0, c[i]};
        return c[7] ? (4'd8 + (4'd8 - ones)) : ones;
    endfunction

    state_t     state, next_state;
    logic [3:0] run, next_run;
    logic       code_legal;
    logic [3:0] code_phase;
    logic [3:0] expected_phase;
    logic       step_ok;
    logic       lock_loss;

    assign code_legal     = is_legal(in_code);
    assign code_phase     = decode(in_code);
    assign expected_phase = phase + 4'd1;
    assign step_ok        = code_legal && (code_phase == expected_phase);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HUNT;
            run   <= 4'd0;
        end else begin
            state <= next_state;
            run   <= next_run;
        end
    end

    // NOTE: defaults first so every path assigns next_state/next_run and no latch is inferred.
    always_comb begin
        next_state = state;
        next_run   = run;
        if (in_valid) begin
            case (state)
                S_HUNT: begin
                    if (code_legal) begin
                        next_run   = 4'd1;
                        next_state = (LOCK_RUN <= 4'd1) ? S_LOCKED : S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (!code_legal) begin
                        next_state = S_HUNT;
                        next_run   = 4'd0;
                    end else if (step_ok) begin
                        next_run = run + 4'd1;
                        if (run + 4'd1 >= LOCK_RUN) next_state = S_LOCKED;
                    end else begin
                        next_run = 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (!step_ok) begin
                        next_state = S_HUNT;
                        next_run   = 4'd0;
                    end
                end
                default: begin
                    next_state = S_HUNT;
                    next_run   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        locked    = (state == S_LOCKED);
        lock_loss = in_valid && (state == S_LOCKED) && !step_ok;
    end

    // phase doubles as the "previous legal phase" used to judge the next step.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= 4'd0;
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            err         <= 1'b0;
        end else begin
            phase_valid <= in_valid && code_legal;
            illegal     <= in_valid && !code_legal;
            if (in_valid && code_legal) phase <= code_phase;
            if (lock_loss)    err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

`ifdef JOHNSON_MON_WRAP_EN
    logic       wrap_step;
    logic [7:0] wraps_q;

    assign wrap_step = in_valid && (state == S_LOCKED) && step_ok && (phase == 4'd15);

    always_ff @(posedge clk) begin
        if (rst)            wraps_q <= 8'd0;
        else if (wrap_step) wraps_q <= wraps_q + 8'd1;
    end

    assign wraps = wraps_q;
`else
    assign wraps = 8'h00;
`endif

endmodule

// File: tb/tb_johnson_monitor.sv
// Scoreboard bench for johnson_monitor: randomized stream vs. a table-driven reference model.
module tb_johnson_monitor;

    localparam int LOCK_COUNT = 4;
    localparam logic [7:0] LEGAL [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                          8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_code = 8'h00;
    logic       err_clr = 1'b0;
    logic [3:0] phase;
    logic       phase_valid, locked, illegal, err;
    logic [7:0] wraps;

    johnson_monitor #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .err_clr(err_clr),
        .phase(phase), .phase_valid(phase_valid), .locked(locked), .illegal(illegal),
        .err(err), .wraps(wraps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] phase;
        logic       pv;
        logic       locked;
        logic       illegal;
        logic       err;
        logic [7:0] wraps;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase is the index of the code in the legal table.
    int   m_phase = 0;
    int   m_run = 0;
    bit   m_locked = 0;
    bit   m_pv = 0;
    bit   m_ill = 0;
    bit   m_err = 0;
    int   m_wraps = 0;

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < 16; i++) if (LEGAL[i] == c) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [7:0] c, input bit clr);
        int  idx;
        bit  correct, loss, wrap;
        if (r) begin
            m_phase = 0; m_run = 0; m_locked = 0; m_pv = 0; m_ill = 0; m_err = 0; m_wraps = 0;
            return;
        end
        idx     = lookup(c);
        correct = (idx >= 0) && (idx == (m_phase + 1) % 16);
        loss    = 0;
        wrap    = 0;
        if (v) begin
            if (m_locked) begin
                if (!correct) begin
                    m_locked = 0; m_run = 0; loss = 1;
                end else if (idx == 0) begin
                    wrap = 1;
                end
            end else if (idx < 0) begin
                m_run = 0;
            end else if (m_run == 0 || !correct) begin
                m_run = 1;
            end else begin
                m_run++;
            end
            if (!m_locked && m_run >= LOCK_COUNT) m_locked = 1;
        end
        m_pv  = v && (idx >= 0);
        m_ill = v && (idx < 0);
        if (m_pv) m_phase = idx;
        if (loss)     m_err = 1;
        else if (clr) m_err = 0;
`ifdef JOHNSON_MON_WRAP_EN
        if (wrap) m_wraps = (m_wraps + 1) % 256;
`endif
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] c, input bit clr);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_code = c; err_clr = clr;
        model(r, v, c, clr);
        e.phase   = 4'(m_phase);
        e.pv      = m_pv;
        e.locked  = m_locked;
        e.illegal = m_ill;
        e.err     = m_err;
        e.wraps   = 8'(m_wraps);
        exp_q.push_back(e);
    endtask

    task automatic step_code(input logic [7:0] c);
        step(0, 1, c, 0);
    endtask

    task automatic step_next();
        step(0, 1, LEGAL[(m_phase + 1) % 16], 0);
    endtask

    // Monitor: every clock edge presents one registered response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("phase",       {4'd0, phase},       {4'd0, e.phase});
                check("phase_valid", {7'd0, phase_valid}, {7'd0, e.pv});
                check("locked",      {7'd0, locked},      {7'd0, e.locked});
                check("illegal",     {7'd0, illegal},     {7'd0, e.illegal});
                check("err",         {7'd0, err},         {7'd0, e.err});
                check("wraps",       wraps,               e.wraps);
            end
        end
    end

    initial begin
        int r;
        int budget;
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h01, 1);
        // Acquire lock, then run past the 15->0 boundary.
        step_code(8'h00); step_code(8'h01); step_code(8'h03); step_code(8'h07); step_code(8'h0F);
        for (int i = 0; i < 16; i++) step_next();
        // Illegal code while locked, then err_clr alone.
        step_code(8'h05);
        step(0, 0, 8'h00, 1);
        // Relock at 03, then a legal but wrong jump to 1F.
        step_code(8'h80); step_code(8'h00); step_code(8'h01); step_code(8'h03);
        step_code(8'h1F);
        // Relock, then repeated code with err_clr in the same cycle: set wins.
        step_code(8'h3F); step_code(8'h7F); step_code(8'hFF); step_code(8'hFE);
        step(0, 1, 8'hFE, 1);
        step(0, 0, 8'h00, 1);
        // Reset mid-lock with in_valid high, then a fresh lock.
        step_code(8'hFC); step_code(8'hF8); step_code(8'hF0); step_code(8'hE0);
        step(1, 1, 8'hC0, 1);
        step_code(8'h01); step_code(8'h03); step_code(8'h07); step_code(8'h0F);
        step_next();
        // Randomized stream, mostly correct steps to exercise long locks and wraps.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 1)        step(1, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
            else if (r < 16)  step(0, 0, 8'($urandom), $urandom_range(0, 9) == 0);
            else if (r < 22)  step(0, 1, 8'($urandom), $urandom_range(0, 9) == 0);
            else if (r < 28)  step(0, 1, LEGAL[$urandom_range(0, 15)], $urandom_range(0, 9) == 0);
            else              step(0, 1, LEGAL[(m_phase + 1) % 16], $urandom_range(0, 29) == 0);
        end
        step(0, 0, 8'h00, 0);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            #2;
            budget++;
        end
        check("drain_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
